// File: rtl/dmem_access_ctrl.sv
// Data-memory strobe initiator: sequences one load/store at a time over a shared
// tri-state bus and returns aligned, optionally sign-extended load data with an error flag.
module dmem_access_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [1:0]       req_mode,
  input  logic             req_signed,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] dmem_addr,
  inout  wire  [WIDTH-1:0] dmem_data,
  output logic             wr,
  output logic             rd,
  input  logic             rd_st,
  output logic [1:0]       data_mode
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] WSTB   = 3'd2;
  localparam logic [2:0] WHOLD  = 3'd3;
  localparam logic [2:0] RDWAIT = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] addr_reg, wdata_reg, rdata_reg, rdata_next;
  logic [1:0]       mode_reg;
  logic             we_reg, signed_reg;
  logic             ready_reg, resp_valid_reg, err_reg, err_next;
  logic             wr_reg, rd_reg, drive_reg, drive_next;
  logic             accept, bad_req;
  logic             fill_b, fill_h;
  logic [WIDTH-1:0] load_ext;

  assign accept  = (state_reg == IDLE) && req_valid && ready_reg;
  assign bad_req = (req_mode == 2'd3)
                || ((req_mode == 2'd0) && (req_addr[1:0] != 2'b00))
                || ((req_mode == 2'd1) && req_addr[0]);

  // Memory returns the accessed bytes right-justified; only the fill above them is ours.
  assign fill_b = signed_reg & dmem_data[7];
  assign fill_h = signed_reg & dmem_data[15];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
      if (gi < 8) begin : g_lo
        assign load_ext[gi] = dmem_data[gi];
      end else if (gi < 16) begin : g_mid
        assign load_ext[gi] = (mode_reg == 2'd2) ? fill_b : dmem_data[gi];
      end else begin : g_hi
        assign load_ext[gi] = (mode_reg == 2'd2) ? fill_b :
                              (mode_reg == 2'd1) ? fill_h : dmem_data[gi];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    drive_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bad_req) begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = '0;
          end else begin
            state_next = SETUP;
            drive_next = req_we;
          end
        end
      end
      SETUP: begin
        state_next = we_reg ? WSTB : RDWAIT;
        drive_next = we_reg;
      end
      WSTB: begin
        state_next = WHOLD;
        drive_next = 1'b1;
      end
      WHOLD: begin
        state_next = RESP;
        err_next   = 1'b0;
        rdata_next = '0;
      end
      RDWAIT: begin
        if (rd_st) begin
          state_next = RESP;
          err_next   = 1'b0;
          rdata_next = load_ext;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RESP;
          err_next   = 1'b1;
          rdata_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is a flop decoded from the next state, so strobes change only on clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mode_reg       <= 2'd0;
      we_reg         <= 1'b0;
      signed_reg     <= 1'b0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      ready_reg      <= 1'b1;
      resp_valid_reg <= 1'b0;
      wr_reg         <= 1'b0;
      rd_reg         <= 1'b0;
      drive_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      ready_reg      <= (state_next == IDLE);
      resp_valid_reg <= (state_next == RESP);
      wr_reg         <= (state_next == WSTB);
      rd_reg         <= (state_next == RDWAIT);
      drive_reg      <= drive_next;
      if (accept) begin
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        mode_reg   <= req_mode;
        we_reg     <= req_we;
        signed_reg <= req_signed;
      end
    end
  end

  assign dmem_data  = drive_reg ? wdata_reg : {WIDTH{1'bz}};
  assign req_ready  = ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign dmem_addr  = addr_reg;
  assign data_mode  = mode_reg;
  assign wr         = wr_reg;
  assign rd         = rd_reg;

endmodule
